// File: rtl/ptmch_pkg.sv
// ----------------------------------------------------------------------------
// ptmch_pkg
// Shared definitions for the SPI instruction-match trigger path:
//   - SPI opcodes the upstream trigger stage matches on
//   - bit positions of each trigger type on the 3-bit trigger pulse bus
//   - event record layout as it leaves the event logger
// ----------------------------------------------------------------------------
package ptmch_pkg;

    // SPI NAND opcodes recognised by the trigger stage
    localparam logic [7:0] OPC_PROG_EXEC = 8'h10;
    localparam logic [7:0] OPC_GET_FEAT  = 8'h0F;
    localparam logic [7:0] OPC_READ_SR   = 8'h05;
    localparam logic [7:0] OPC_BLK_ERASE = 8'hD8;

    // Trigger pulse bus bit indices
    localparam int TRG_PE = 0;  // program-execute
    localparam int TRG_RS = 1;  // read-status
    localparam int TRG_BE = 2;  // 128KB block-erase

    // Event record at the default timestamp width
    localparam int EVT_TS_W = 32;

    typedef struct packed {
        logic [2:0]          code;
        logic [EVT_TS_W-1:0] ts;
    } evt_t;

endpackage

// File: rtl/ptmch_evt_fifo.sv
// ----------------------------------------------------------------------------
// ptmch_evt_fifo
// Single-clock synchronous FIFO with a registered head. A push into an empty
// FIFO is visible on rdata the cycle after the write (no fall-through). The
// head register only changes on a pop or on the first push into an empty
// FIFO, so rdata holds steady while the consumer stalls.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, wdata   write request and data (dropped when full without a pop)
//   pop           read request (ignored when empty)
//   rdata         current head entry
//   full, empty   occupancy flags
//   level         entry count, 0..P_DEPTH
// ----------------------------------------------------------------------------
module ptmch_evt_fifo #(
    parameter int P_DEPTH = 16,
    parameter int P_W     = 35
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [P_W-1:0]             wdata,
    input  logic                       pop,
    output logic [P_W-1:0]             rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(P_DEPTH):0]   level
);

    localparam int AW = $clog2(P_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [P_W-1:0] mem [P_DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [AW:0]    rd_ptr_nxt;
    logic           push_ok;
    logic           pop_ok;

    // Extra MSB on the pointers distinguishes full from empty
    assign level  = wr_ptr - rd_ptr;
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push
    assign push_ok    = push && (!full || pop_ok);
    assign rd_ptr_nxt = pop_ok ? (rd_ptr + PTR_ONE) : rd_ptr;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdata  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr <= rd_ptr_nxt;
            // Next head is either the entry being written right now (FIFO
            // drains to it this cycle) or an entry already in storage.
            if (push_ok && (rd_ptr_nxt == wr_ptr)) begin
                rdata <= wdata;
            end else if (rd_ptr_nxt != wr_ptr) begin
                rdata <= mem[rd_ptr_nxt[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/ptmch_evt_log.sv
// ----------------------------------------------------------------------------
// ptmch_evt_log
// Timestamps every onset on the trigger pulse bus, queues {code, timestamp}
// records in a FIFO drained over valid/ready, and keeps per-type saturating
// onset counters plus a sticky overflow flag.
// Ports:
//   CLK200M            sole clock
//   RESET              asynchronous active-high reset
//   TRG_PLS[2:0]       trigger pulses (bit0 PE, bit1 RS, bit2 BE)
//   CLR_CNT            synchronous clear of counters and OVF
//   EVT_VALID/READY    event stream handshake
//   EVT_DATA           {code[2:0], timestamp}
//   FIFO_LVL           entries currently queued
//   OVF                sticky: an event was dropped on a full FIFO
//   CNT_PE/RS/BE       saturating onset counters per trigger type
// ----------------------------------------------------------------------------
module ptmch_evt_log
    import ptmch_pkg::*;
#(
    parameter int P_DEPTH = 16,
    parameter int P_TS_W  = 32,
    parameter int P_CNT_W = 16
) (
    input  logic                       CLK200M,
    input  logic                       RESET,
    input  logic [2:0]                 TRG_PLS,
    input  logic                       CLR_CNT,
    output logic                       EVT_VALID,
    input  logic                       EVT_READY,
    output logic [P_TS_W+2:0]          EVT_DATA,
    output logic [$clog2(P_DEPTH):0]   FIFO_LVL,
    output logic                       OVF,
    output logic [P_CNT_W-1:0]         CNT_PE,
    output logic [P_CNT_W-1:0]         CNT_RS,
    output logic [P_CNT_W-1:0]         CNT_BE
);

    localparam logic [P_TS_W-1:0]  TS_ONE  = {{(P_TS_W-1){1'b0}}, 1'b1};
    localparam logic [P_CNT_W-1:0] CNT_ONE = {{(P_CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]        trg_q;
    logic [2:0]        trg_q_d;
    logic [2:0]        rise_q;
    logic [P_TS_W-1:0] ts_cnt;
    logic              evt_push;
    logic              evt_pop;
    logic              evt_drop;
    logic              fifo_full;
    logic              fifo_empty;

    function automatic logic [P_CNT_W-1:0] sat_inc(input logic [P_CNT_W-1:0] v);
        return (&v) ? v : (v + CNT_ONE);
    endfunction

    // Clear wins over the old value but not over an onset in the same cycle
    function automatic logic [P_CNT_W-1:0] cnt_next(input logic [P_CNT_W-1:0] v,
                                                    input logic inc,
                                                    input logic clr);
        if (clr) begin
            return inc ? CNT_ONE : '0;
        end
        return inc ? sat_inc(v) : v;
    endfunction

    // Stage 1: input register and edge-detect history
    always_ff @(posedge CLK200M or posedge RESET) begin
        if (RESET) begin
            trg_q   <= '0;
            trg_q_d <= '0;
            ts_cnt  <= '0;
        end else begin
            trg_q   <= TRG_PLS;
            trg_q_d <= trg_q;
            ts_cnt  <= ts_cnt + TS_ONE;
        end
    end

    // Stage 2: registered onset vector
    always_ff @(posedge CLK200M or posedge RESET) begin
        if (RESET) begin
            rise_q <= '0;
        end else begin
            rise_q <= trg_q & ~trg_q_d;
        end
    end

    // Stage 3: FIFO write, counters and overflow flag
    assign evt_push  = |rise_q;
    assign EVT_VALID = ~fifo_empty;
    assign evt_pop   = EVT_VALID & EVT_READY;
    assign evt_drop  = evt_push & fifo_full & ~evt_pop;

    ptmch_evt_fifo #(
        .P_DEPTH (P_DEPTH),
        .P_W     (P_TS_W + 3)
    ) u_fifo (
        .clk   (CLK200M),
        .rst   (RESET),
        .push  (evt_push),
        .wdata ({rise_q, ts_cnt}),
        .pop   (evt_pop),
        .rdata (EVT_DATA),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (FIFO_LVL)
    );

    always_ff @(posedge CLK200M or posedge RESET) begin
        if (RESET) begin
            CNT_PE <= '0;
            CNT_RS <= '0;
            CNT_BE <= '0;
            OVF    <= 1'b0;
        end else begin
            CNT_PE <= cnt_next(CNT_PE, rise_q[TRG_PE], CLR_CNT);
            CNT_RS <= cnt_next(CNT_RS, rise_q[TRG_RS], CLR_CNT);
            CNT_BE <= cnt_next(CNT_BE, rise_q[TRG_BE], CLR_CNT);
            // A drop in the clear cycle still leaves the flag set
            OVF    <= evt_drop | (OVF & ~CLR_CNT);
        end
    end

endmodule

// File: tb/tb_ptmch_evt_log.sv
module tb_ptmch_evt_log;

    localparam int DEPTH = 16;

    logic        CLK200M;
    logic        RESET;
    logic [2:0]  TRG_PLS;
    logic        CLR_CNT;
    logic        EVT_READY;

    logic        EVT_VALID;
    logic [34:0] EVT_DATA;
    logic [4:0]  FIFO_LVL;
    logic        OVF;
    logic [15:0] CNT_PE, CNT_RS, CNT_BE;

    logic        s_valid;
    logic [34:0] s_data;
    logic [4:0]  s_lvl;
    logic        s_ovf;
    logic [3:0]  s_pe, s_rs, s_be;

    int checks = 0;
    int errors = 0;

    ptmch_evt_log dut (
        .CLK200M(CLK200M), .RESET(RESET), .TRG_PLS(TRG_PLS), .CLR_CNT(CLR_CNT),
        .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_DATA(EVT_DATA),
        .FIFO_LVL(FIFO_LVL), .OVF(OVF),
        .CNT_PE(CNT_PE), .CNT_RS(CNT_RS), .CNT_BE(CNT_BE)
    );

    ptmch_evt_log #(.P_CNT_W(4)) dut_sat (
        .CLK200M(CLK200M), .RESET(RESET), .TRG_PLS(TRG_PLS), .CLR_CNT(CLR_CNT),
        .EVT_VALID(s_valid), .EVT_READY(EVT_READY), .EVT_DATA(s_data),
        .FIFO_LVL(s_lvl), .OVF(s_ovf),
        .CNT_PE(s_pe), .CNT_RS(s_rs), .CNT_BE(s_be)
    );

    initial CLK200M = 1'b0;
    always #5 CLK200M = ~CLK200M;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: an onset seen on the bus becomes a queued record
    // two clocks after the first high sample, stamped with the cycle count
    // since reset at that time.
    // ------------------------------------------------------------------
    logic [2:0]  s1 = '0, s2 = '0, s3 = '0;
    logic [31:0] m_ts = '0;
    logic [34:0] mq[$];
    int          m_cnt[3] = '{0, 0, 0};
    bit          m_ovf = 1'b0;

    always @(posedge CLK200M) begin : model
        logic [2:0] code;
        bit         pop_now;
        bit         drop;
        if (RESET) begin
            mq.delete();
            s1 = '0; s2 = '0; s3 = '0;
            m_ts = '0;
            m_cnt = '{0, 0, 0};
            m_ovf = 1'b0;
        end else begin
            code    = s2 & ~s3;
            pop_now = (mq.size() != 0) && EVT_READY;
            drop    = 1'b0;
            if (pop_now) void'(mq.pop_front());
            if (code != 3'b000) begin
                if (mq.size() < DEPTH) mq.push_back({code, m_ts});
                else drop = 1'b1;
            end
            for (int b = 0; b < 3; b++) begin
                if (CLR_CNT) m_cnt[b] = code[b] ? 1 : 0;
                else if (code[b]) m_cnt[b] = m_cnt[b] + 1;
            end
            if (drop) m_ovf = 1'b1;
            else if (CLR_CNT) m_ovf = 1'b0;
            s3 = s2; s2 = s1; s1 = TRG_PLS;
            m_ts = m_ts + 32'd1;
            #1;
            chk("m_valid", EVT_VALID, mq.size() != 0);
            chk("m_lvl", FIFO_LVL, mq.size());
            chk("m_ovf", OVF, m_ovf);
            chk("m_cnt_pe", CNT_PE, sat(m_cnt[0], 16));
            chk("m_cnt_rs", CNT_RS, sat(m_cnt[1], 16));
            chk("m_cnt_be", CNT_BE, sat(m_cnt[2], 16));
            chk("m_s_valid", s_valid, mq.size() != 0);
            chk("m_s_lvl", s_lvl, mq.size());
            chk("m_s_ovf", s_ovf, m_ovf);
            chk("m_s_cnt_pe", s_pe, sat(m_cnt[0], 4));
            chk("m_s_cnt_rs", s_rs, sat(m_cnt[1], 4));
            chk("m_s_cnt_be", s_be, sat(m_cnt[2], 4));
            if (mq.size() != 0) begin
                chk("m_data", EVT_DATA, mq[0]);
                chk("m_s_data", s_data, mq[0]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus; every task starts and ends on a falling edge
    // ------------------------------------------------------------------
    task automatic pulse(input logic [2:0] b);
        TRG_PLS = b;
        repeat (15) @(negedge CLK200M);
        TRG_PLS = 3'b000;
        repeat (3) @(negedge CLK200M);
    endtask

    task automatic clear_cnt();
        CLR_CNT = 1'b1;
        @(negedge CLK200M);
        CLR_CNT = 1'b0;
    endtask

    // Called on the falling edge where reset was released: the pulse is
    // first sampled on clock 5, so the record carries ts 6 and shows on clock 7.
    task automatic single_pe();
        repeat (4) @(negedge CLK200M);
        TRG_PLS = 3'b001;
        @(negedge CLK200M);
        @(negedge CLK200M);
        chk("sp_valid_early", EVT_VALID, 1'b0);
        @(negedge CLK200M);
        chk("sp_valid", EVT_VALID, 1'b1);
        chk("sp_data", EVT_DATA, {3'b001, 32'd6});
        repeat (12) @(negedge CLK200M);
        TRG_PLS = 3'b000;
        repeat (3) @(negedge CLK200M);
        chk("sp_cnt_pe", CNT_PE, 16'd1);
        chk("sp_lvl_after", FIFO_LVL, 5'd0);
    endtask

    int          peak;
    logic [2:0]  seen_code;
    logic [34:0] d0;
    int          n, bad;
    logic [31:0] prev_ts, ts_now, first_step;

    initial begin
        RESET = 1'b1; TRG_PLS = 3'b000; CLR_CNT = 1'b0; EVT_READY = 1'b1;
        repeat (3) @(negedge CLK200M);
        chk("rst_valid", EVT_VALID, 1'b0);
        chk("rst_data", EVT_DATA, 35'd0);
        chk("rst_lvl", FIFO_LVL, 5'd0);
        chk("rst_ovf", OVF, 1'b0);
        chk("rst_cnt_pe", CNT_PE, 16'd0);
        chk("rst_cnt_be", CNT_BE, 16'd0);
        RESET = 1'b0;

        // Single pulse
        single_pe();

        // Simultaneous rise on bits 1 and 2
        clear_cnt();
        peak = 0; seen_code = '0;
        TRG_PLS = 3'b110;
        for (int i = 0; i < 18; i++) begin
            if (i == 15) TRG_PLS = 3'b000;
            @(negedge CLK200M);
            if (int'(FIFO_LVL) > peak) peak = int'(FIFO_LVL);
            if (EVT_VALID) seen_code = EVT_DATA[34:32];
        end
        chk("sim_peak", peak, 1);
        chk("sim_code", seen_code, 3'b110);
        chk("sim_cnt_rs", CNT_RS, 16'd1);
        chk("sim_cnt_be", CNT_BE, 16'd1);
        chk("sim_cnt_pe", CNT_PE, 16'd0);

        // Overflow with the consumer stalled
        clear_cnt();
        EVT_READY = 1'b0;
        repeat (17) pulse(3'b100);
        chk("ovf_lvl", FIFO_LVL, 5'd16);
        chk("ovf_flag", OVF, 1'b1);
        chk("ovf_cnt_be", CNT_BE, 16'd17);
        chk("ovf_sat_cnt_be", s_be, 4'd15);

        // Backpressure: head must not move
        d0 = EVT_DATA;
        repeat (5) begin
            @(negedge CLK200M);
            chk("bp_valid", EVT_VALID, 1'b1);
            chk("bp_hold", EVT_DATA, d0);
        end

        // Full FIFO, push and pop in the same clock
        clear_cnt();
        chk("clr_ovf", OVF, 1'b0);
        TRG_PLS = 3'b100;
        @(negedge CLK200M);
        @(negedge CLK200M);
        EVT_READY = 1'b1;
        @(negedge CLK200M);
        EVT_READY = 1'b0;
        chk("fpp_lvl", FIFO_LVL, 5'd16);
        chk("fpp_ovf", OVF, 1'b0);
        chk("fpp_cnt_be", CNT_BE, 16'd1);
        repeat (12) @(negedge CLK200M);
        TRG_PLS = 3'b000;
        repeat (3) @(negedge CLK200M);

        // Drain
        n = 0; bad = 0; prev_ts = '0; first_step = '0;
        EVT_READY = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (EVT_VALID) begin
                ts_now = EVT_DATA[31:0];
                if (n == 1) first_step = ts_now - prev_ts;
                if (n > 0 && ts_now <= prev_ts) bad++;
                prev_ts = ts_now;
                n++;
            end
            @(negedge CLK200M);
        end
        chk("drain_count", n, 16);
        chk("drain_order", bad, 0);
        chk("drain_step", first_step, 32'd18);

        // Counter saturation
        clear_cnt();
        repeat (20) pulse(3'b001);
        chk("sat_cnt_pe_wide", CNT_PE, 16'd20);
        chk("sat_cnt_pe_4b", s_pe, 4'd15);

        // Clear coinciding with an onset
        TRG_PLS = 3'b001;
        @(negedge CLK200M);
        @(negedge CLK200M);
        CLR_CNT = 1'b1;
        @(negedge CLK200M);
        CLR_CNT = 1'b0;
        chk("clr_rise_pe", CNT_PE, 16'd1);
        chk("clr_rise_pe_4b", s_pe, 4'd1);
        chk("clr_rise_ovf", OVF, 1'b0);
        repeat (12) @(negedge CLK200M);
        TRG_PLS = 3'b000;
        repeat (3) @(negedge CLK200M);

        // Reset mid-operation with entries queued
        EVT_READY = 1'b0;
        repeat (3) pulse(3'b010);
        chk("mr_lvl_before", FIFO_LVL, 5'd3);
        RESET = 1'b1;
        #1;
        chk("mr_lvl", FIFO_LVL, 5'd0);
        chk("mr_valid", EVT_VALID, 1'b0);
        chk("mr_data", EVT_DATA, 35'd0);
        chk("mr_cnt_rs", CNT_RS, 16'd0);
        @(negedge CLK200M);
        @(negedge CLK200M);
        RESET = 1'b0;
        EVT_READY = 1'b1;
        single_pe();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ptmch_evt_log.md
# ptmch_evt_log

Trigger event logger that sits directly downstream of the SPI instruction-match trigger stage. It consumes the 3-bit trigger pulse bus (bit 0 program-execute, bit 1 read-status, bit 2 128KB block-erase) and timestamps every pulse onset. Events are queued in a small FIFO and drained over a valid/ready interface. The block also keeps per-type saturating event counters and a sticky overflow flag for host readout.

## Interface
Parameters:
- P_DEPTH, 16, FIFO depth in entries; power of two, minimum 2
- P_TS_W, 32, timestamp width in bits
- P_CNT_W, 16, width of each per-type event counter

Ports:
- CLK200M  in  1  sole clock, 200 MHz; TRG_PLS is synchronous to it
- RESET  in  1  asynchronous, active-high reset
- TRG_PLS  in  3  trigger pulses from the trigger stage; each pulse is 15 cycles wide
- CLR_CNT  in  1  synchronous clear of the counters and of OVF; FIFO contents are kept
- EVT_VALID  out  1  FIFO head is valid
- EVT_READY  in  1  consumer accepts the head entry
- EVT_DATA  out  P_TS_W+3  {code[2:0], timestamp[P_TS_W-1:0]}
- FIFO_LVL  out  $clog2(P_DEPTH)+1  current entry count
- OVF  out  1  sticky flag: set when an event is dropped
- CNT_PE, CNT_RS, CNT_BE  out  P_CNT_W each  onset counts for bits 0, 1 and 2

## Operation
- Input register: TRG_PLS is registered into trg_q, then trg_q_d. The rise vector is trg_q & ~trg_q_d. The register removes combinational glitches from the upstream comparator.
- Timestamp counter ts_cnt:
  - 0 after reset, +1 every cycle.
  - Wraps modulo 2^P_TS_W silently.
  - Not affected by CLR_CNT.
- Push condition: rise != 0.
  - Entry written is {rise, ts_cnt} from the detection cycle.
  - Several bits rising in the same cycle produce one entry with several code bits set.
- Pop condition: EVT_VALID & EVT_READY.
- FIFO rules:
  - Full with no pop: the push is dropped and OVF is set.
  - Full with a pop in the same cycle: the push is accepted and FIFO_LVL is unchanged.
  - Empty with a push: the entry appears the following cycle. There is no fall-through.
  - Push and pop in the same cycle at any level: both take effect.
- Output stability: EVT_DATA must stay stable while EVT_VALID & ~EVT_READY. EVT_DATA is don't-care when EVT_VALID=0.
- Counters:
  - Each counter increments on its rise bit and saturates at all-ones; it never wraps.
  - A counter increments even when the entry is dropped.
- CLR_CNT:
  - Zeroes all three counters and OVF.
  - A rise in the same cycle as CLR_CNT leaves that counter at 1.
  - A drop in the same cycle as CLR_CNT leaves OVF=1.
- RESET, including mid-operation: every state element returns to its reset value, the FIFO is emptied, and in-flight events are lost.

## Timing
- Reset values: EVT_VALID=0, EVT_DATA=0, FIFO_LVL=0, OVF=0, all counters 0, ts_cnt=0, trg_q=trg_q_d=0.
- Latency: TRG_PLS first sampled high at edge N → rise asserted after edge N+1 → entry written and EVT_VALID=1 after edge N+2.
- Timestamp value: the stored timestamp equals ts_cnt as seen between edges N+1 and N+2.
- Counter and OVF updates happen at edge N+2, the same edge as the write.
- Pop: an accepted pop at edge M shows the next head, or EVT_VALID=0, after edge M.
- Throughput: one push and one pop per cycle maximum.

## Structure
- Shared package ptmch_pkg holds:
  - the instruction opcode constants (0x10, 0x0F, 0x05, 0xD8);
  - the trigger bit indices TRG_PE=0, TRG_RS=1, TRG_BE=2;
  - typedef evt_t, a packed struct {logic [2:0] code; logic [P_TS_W-1:0] ts}.
- Sub-module ptmch_evt_fifo: a synchronous single-clock FIFO.
  - Register-array storage, with extra-bit read/write pointers of width $clog2(P_DEPTH)+1.
  - Signals: full, empty, level.
  - Registered read data is kept stable under backpressure.
- Everything else (input register, edge detect, timestamp, counters, OVF) lives in ptmch_evt_log.

## Test plan
- Single pulse: TRG_PLS=3'b001 for 15 cycles, EVT_READY=1 → exactly one entry with code=3'b001 and ts equal to the detection-cycle ts_cnt. EVT_VALID rises 2 cycles after the first high sample. CNT_PE=1.
- Simultaneous rise: bits 1 and 2 rise in the same cycle → one entry with code=3'b110. CNT_RS=1, CNT_BE=1, FIFO_LVL peaks at 1.
- Overflow: EVT_READY=0 and 17 separated pulses on bit 2 → FIFO_LVL=16, OVF=1, CNT_BE=17. Draining then yields 16 entries with increasing timestamps.
- Full with concurrent push and pop: FIFO full, a pop in the same cycle as a push → FIFO_LVL stays 16, OVF stays 0.
- Backpressure and saturation:
  - Hold EVT_READY=0 for 5 cycles with the FIFO non-empty → EVT_DATA unchanged throughout.
  - With P_CNT_W=4, 20 pulses on bit 0 → CNT_PE=15.
- Clear and reset:
  - CLR_CNT in the same cycle as a bit-0 rise → CNT_PE=1, OVF=0.
  - RESET asserted with 3 entries queued → FIFO_LVL=0 and EVT_VALID=0 immediately; ts_cnt restarts at 0.
